// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//    Iterative MIPS-style HI/LO multiply/divide unit. One operation takes 32
//    RUN steps plus one FINISH cycle; the result lands in HI/LO with a
//    one-cycle done pulse. HI/LO can also be loaded directly (MTHI/MTLO)
//    while the unit is idle.
//
// Ports
//    clk        rising-edge clock
//    reset      synchronous, active-high reset
//    start      begin an operation (only honoured in IDLE)
//    op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    a, b       operands (multiplicand/dividend, multiplier/divisor)
//    hiWrite    load writeData into HI (IDLE only)
//    loWrite    load writeData into LO (IDLE only)
//    writeData  data for hiWrite/loWrite
//    busy       high in RUN and FINISH
//    done       one-cycle pulse when HI/LO receive a result
//    hi, lo     HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t             state;
   state_t             nextState;
   logic [4:0]         count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic               isDiv;
   logic               resNeg;
   logic               remNeg;

   logic               signedOp;
   logic               aNeg;
   logic               bNeg;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divUpper;
   logic [2*WIDTH-1:0] divNext;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   resHi;
   logic [WIDTH-1:0]   resLo;

   // Next-state logic and busy flag. RUN lasts exactly 32 cycles, counted by
   // the 5-bit step counter that wraps back to zero on the last step.
   always_comb begin
      nextState = state;
      busy      = (state != IDLE);
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (count == 5'd31) nextState = FINISH;
         FINISH:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand conditioning at start: the core only ever works on magnitudes,
   // and the signs are remembered for correction in FINISH. A zero divisor
   // leaves the quotient uncorrected so it stays all ones, while the
   // remainder picks the dividend sign back up and therefore equals a.
   always_comb begin
      signedOp = ~op[0];
      aNeg     = signedOp & a[WIDTH-1];
      bNeg     = signedOp & b[WIDTH-1];
      magA     = aNeg ? -a : a;
      magB     = bNeg ? -b : b;
   end

   // One iteration of each algorithm. Multiply adds the multiplicand into
   // the upper half when the current multiplier bit is set, then shifts the
   // 65-bit sum right. Divide shifts the remainder/quotient pair left and
   // keeps the trial subtraction only if the divisor fits (restoring).
   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      mulNext  = {mulSum, acc[WIDTH-1:1]};
      divUpper = acc[2*WIDTH-1:WIDTH-1];
      if (divUpper >= {1'b0, operand}) begin
         divNext = {divUpper[WIDTH-1:0] - operand, acc[WIDTH-2:0], 1'b1};
      end else begin
         divNext = {divUpper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction applied in FINISH. Negating the most negative value
   // yields itself, which is exactly the required 0x80000000 / -1 result.
   always_comb begin
      product = resNeg ? -acc : acc;
      quot    = resNeg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem     = remNeg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      resHi   = isDiv ? rem  : product[2*WIDTH-1:WIDTH];
      resLo   = isDiv ? quot : product[WIDTH-1:0];
   end

   // State, datapath and HI/LO registers. HI/LO only change on an idle
   // MTHI/MTLO or at the FINISH edge, so partial accumulator values never
   // appear on the outputs. Reset aborts any operation without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         operand <= '0;
         isDiv   <= 1'b0;
         resNeg  <= 1'b0;
         remNeg  <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state <= nextState;
         done  <= (state == FINISH);
         case (state)
            IDLE: begin
               if (hiWrite) hi <= writeData;
               if (loWrite) lo <= writeData;
               if (start) begin
                  isDiv   <= op[1];
                  count   <= '0;
                  operand <= op[1] ? magB : magA;
                  acc     <= {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
                  resNeg  <= (aNeg ^ bNeg) & (b != '0);
                  remNeg  <= aNeg;
               end
            end
            RUN: begin
               acc   <= isDiv ? divNext : mulNext;
               count <= count + 5'd1;
            end
            FINISH: begin
               hi <= resHi;
               lo <= resLo;
            end
            default: ;
         endcase
      end
   end

endmodule
